// File: rtl/dsp_pkg.sv
// Shared widths, operand-select encodings and opmode bit positions for the DSP post-adder.
package dsp_pkg;

    localparam int unsigned P_W    = 48;
    localparam int unsigned M_W    = 36;
    localparam int unsigned AB_W   = 18;
    localparam int unsigned D_LO_W = 12;
    localparam int unsigned OPM_W  = 8;

    localparam int unsigned OPM_X_LSB   = 0;
    localparam int unsigned OPM_Z_LSB   = 2;
    localparam int unsigned OPM_CIN_BIT = 5;
    localparam int unsigned OPM_SUB_BIT = 7;

    typedef enum logic [1:0] {
        X_ZERO = 2'd0,
        X_MULT = 2'd1,
        X_PFB  = 2'd2,
        X_DAB  = 2'd3
    } x_sel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PCIN = 2'd1,
        Z_PFB  = 2'd2,
        Z_C    = 2'd3
    } z_sel_e;

    // D:A:B concatenation as seen by the X mux (only the low 12 bits of D fit).
    typedef struct packed {
        logic [D_LO_W-1:0] d;
        logic [AB_W-1:0]   a;
        logic [AB_W-1:0]   b;
    } dab_t;

endpackage

// File: rtl/dsp_reg_bypass.sv
// Optional pipeline stage: synchronous active-high reset, clock enable, register-or-bypass output.
module dsp_reg_bypass #(
    parameter int unsigned WIDTH  = 1,
    parameter bit          EN_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r;

    // Reset wins over the clock enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
        end else if (ce) begin
            r <= d;
        end
    end

    assign q = EN_REG ? r : d;

endmodule

// File: rtl/dsp_post_adder.sv
// DSP48A1-style post-adder/accumulator: X/Z operand select, add/subtract with carry, P/CARRYOUT stage.
// Define DSP_POSTADD_OVF_EN to add the registered signed-overflow output OVF.
module dsp_post_adder
    import dsp_pkg::*;
#(
    parameter int unsigned OPMODEREG   = 1,
    parameter int unsigned CARRYINREG  = 1,
    parameter int unsigned PREG        = 1,
    parameter int unsigned CARRYOUTREG = 1,
    parameter string       CARRYINSEL  = "OPMODE5"
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [OPM_W-1:0] opmode,
    input  logic [M_W-1:0]   M,
    input  logic [P_W-1:0]   C,
    input  logic [AB_W-1:0]  D,
    input  logic [AB_W-1:0]  A,
    input  logic [AB_W-1:0]  B,
    input  logic [P_W-1:0]   PCIN,
    input  logic             carryin,
    input  logic             CEOPMODE,
    input  logic             CECARRYIN,
    input  logic             CEP,
    output logic [P_W-1:0]   P,
    output logic [P_W-1:0]   PCOUT,
    output logic             CARRYOUT,
    output logic             CARRYOUTF
`ifdef DSP_POSTADD_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam bit CIN_FROM_PORT = (CARRYINSEL == "CARRYIN");
    localparam bit OPM_EN        = (OPMODEREG != 0);
    localparam bit CIN_EN        = (CARRYINREG != 0);
    localparam bit OPM_PAD_EN    = CIN_EN && !OPM_EN;
    localparam bit CIN_PAD_EN    = OPM_EN && !CIN_EN;
    localparam bit PREG_EN       = (PREG != 0);
    localparam bit COREG_EN      = (CARRYOUTREG != 0);

    logic [OPM_W-1:0] opm_s1;
    logic [OPM_W-1:0] opm_r;
    logic             cin_raw;
    logic             cin_s1;
    logic             cin_r;
    logic [P_W-1:0]   p_reg;
    logic [P_W-1:0]   x_op;
    logic [P_W-1:0]   z_op;
    logic [P_W:0]     sum;
    logic             sub;
    logic             co;
    dab_t             dab;

    // Opmode path; the pad stage only exists when the carry path is the longer one.
    dsp_reg_bypass #(.WIDTH(OPM_W), .EN_REG(OPM_EN)) u_opm_reg (
        .clk(clk), .rst(rstn), .ce(CEOPMODE),  .d(opmode), .q(opm_s1)
    );
    dsp_reg_bypass #(.WIDTH(OPM_W), .EN_REG(OPM_PAD_EN)) u_opm_pad (
        .clk(clk), .rst(rstn), .ce(CECARRYIN), .d(opm_s1), .q(opm_r)
    );

    // Carry source is picked before the stage so it lines up with the opmode it came with.
    assign cin_raw = CIN_FROM_PORT ? carryin : opmode[OPM_CIN_BIT];

    dsp_reg_bypass #(.WIDTH(1), .EN_REG(CIN_EN)) u_cin_reg (
        .clk(clk), .rst(rstn), .ce(CECARRYIN), .d(cin_raw), .q(cin_s1)
    );
    dsp_reg_bypass #(.WIDTH(1), .EN_REG(CIN_PAD_EN)) u_cin_pad (
        .clk(clk), .rst(rstn), .ce(CEOPMODE),  .d(cin_s1), .q(cin_r)
    );

    assign dab = '{d: D[D_LO_W-1:0], a: A, b: B};
    assign sub = opm_r[OPM_SUB_BIT];

    // Operand muxes; P feedback always comes from the P register, even in bypass builds.
    always_comb begin
        x_op = '0;
        z_op = '0;
        case (x_sel_e'(opm_r[OPM_X_LSB +: 2]))
            X_ZERO: x_op = '0;
            X_MULT: x_op = P_W'(M);
            X_PFB:  x_op = p_reg;
            X_DAB:  x_op = dab;
        endcase
        case (z_sel_e'(opm_r[OPM_Z_LSB +: 2]))
            Z_ZERO: z_op = '0;
            Z_PCIN: z_op = PCIN;
            Z_PFB:  z_op = p_reg;
            Z_C:    z_op = C;
        endcase
    end

    // 49-bit add/subtract; bit 48 is the carry on add and the borrow on subtract.
    always_comb begin
        sum = '0;
        if (sub) begin
            sum = {1'b0, z_op} - ({1'b0, x_op} + (P_W + 1)'(cin_r));
        end else begin
            sum = {1'b0, z_op} + {1'b0, x_op} + (P_W + 1)'(cin_r);
        end
    end

    dsp_reg_bypass #(.WIDTH(P_W), .EN_REG(1'b1)) u_p_reg (
        .clk(clk), .rst(rstn), .ce(CEP), .d(sum[P_W-1:0]), .q(p_reg)
    );

    dsp_reg_bypass #(.WIDTH(1), .EN_REG(COREG_EN)) u_co_reg (
        .clk(clk), .rst(rstn), .ce(CEP), .d(sum[P_W]), .q(co)
    );

    assign P         = PREG_EN ? p_reg : sum[P_W-1:0];
    assign PCOUT     = P;
    assign CARRYOUT  = co;
    assign CARRYOUTF = co;

`ifdef DSP_POSTADD_OVF_EN
    logic [P_W-1:0] neg_x;
    logic           b_sign;
    logic           ovf_c;

    // Signed overflow: both effective operands share a sign that the result does not.
    always_comb begin
        neg_x  = P_W'(0) - x_op;
        b_sign = sub ? neg_x[P_W-1] : x_op[P_W-1];
        ovf_c  = (z_op[P_W-1] == b_sign) && (sum[P_W-1] != z_op[P_W-1]);
    end

    dsp_reg_bypass #(.WIDTH(1), .EN_REG(COREG_EN)) u_ovf_reg (
        .clk(clk), .rst(rstn), .ce(CEP), .d(ovf_c), .q(OVF)
    );
`endif

    logic unused_bits;
    assign unused_bits = ^{opm_r[6], opm_r[5], opm_r[4], D[AB_W-1:D_LO_W]};

endmodule
